// File: rtl/s_type_store_pkg.sv
// Shared load/store definitions for the RV32I data-memory path: opcodes,
// funct3 encodings, lane geometry and the store request FSM states.
package s_type_store_pkg;

  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef logic [NUM_LANES-1:0] be_t;

  typedef enum logic {IDLE, REQ} state_t;

  function automatic logic st_f3_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/s_type_store_align.sv
// Combinational lane steering for SB/SH/SW: replicates store data across the
// byte lanes, picks byte enables from ea[1:0] and flags misaligned SH/SW.
module store_align
  import s_type_store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] in2,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
  be_t                              lane_be;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int HALF = i / 2;
    localparam int HSEL = i % 2;
    logic [LANE_W-1:0] d;
    logic              en;

    always_comb begin
      d  = in2[LANE_W*i +: LANE_W];
      en = 1'b0;
      case (funct3)
        F3_SB: begin
          d  = in2[LANE_W-1:0];
          en = (ea_lo == 2'(i));
        end
        // Halfword lanes follow ea[1] only; ea[0] is either rejected or dropped.
        F3_SH: begin
          d  = in2[LANE_W*HSEL +: LANE_W];
          en = (ea_lo[1] == 1'(HALF));
        end
        F3_SW: en = 1'b1;
        default: ;
      endcase
    end

    assign lanes[i]   = d;
    assign lane_be[i] = en;
  end

  assign wdata = lanes;
  assign be    = lane_be;

  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_SH:   misaligned = ea_lo[0];
      F3_SW:   misaligned = (ea_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/s_type_store.sv
// S-type store port: computes rs1+imm, steers rs2 onto byte lanes and holds a
// valid/ready write request until memory accepts. STORE_MISALIGN_CHECK_EN
// enables rejection of misaligned SH/SW with a one-cycle misalign pulse.
module s_type_store
  import s_type_store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [11:0]       imm,
  input  logic [31:0]       in1,
  input  logic [31:0]       in2,
  output logic              busy,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [ADDR_W-1:0] d_addr,
  output logic [31:0]       d_wdata,
  output logic [3:0]        d_be,
  output logic              st_done,
  output logic              misalign
);

  state_t      state;
  logic [31:0] ea;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_mis;
  logic        accept;
  logic        reject;

  assign ea     = in1 + {{20{imm[11]}}, imm};
  assign accept = issue && (opcode == OPC_STORE) && st_f3_legal(funct3);

  store_align u_align (
    .funct3     (funct3),
    .ea_lo      (ea[1:0]),
    .in2        (in2),
    .wdata      (al_wdata),
    .be         (al_be),
    .misaligned (al_mis)
  );

`ifdef STORE_MISALIGN_CHECK_EN
  assign reject = al_mis;
`else
  // Without the check, SW drops ea[1:0] and SH steers on ea[1] alone.
  assign reject = 1'b0;
  logic unused_mis;
  assign unused_mis = al_mis;
`endif

  assign d_valid = (state == REQ);
  assign busy    = d_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      d_addr   <= '0;
      d_wdata  <= '0;
      d_be     <= '0;
      st_done  <= 1'b0;
      misalign <= 1'b0;
    end else begin
      st_done  <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (reject) begin
              misalign <= 1'b1;
            end else begin
              state   <= REQ;
              d_addr  <= {ea[ADDR_W-1:2], 2'b00};
              d_wdata <= al_wdata;
              d_be    <= al_be;
            end
          end
        end
        REQ: begin
          if (d_ready) begin
            state   <= IDLE;
            st_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/s_type_store.md
# s_type_store

Store-side data-memory port for the RV32I core: accepts an S-type instruction (SB/SH/SW), computes the effective address rs1 + sign-extended imm, steers rs2 onto the correct byte lanes with matching byte enables, and drives a registered valid/ready write request to data memory. It is the write counterpart to the load path and shares the same data-memory address space. It holds the pipeline with a busy flag until memory accepts the write.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- Data width fixed at 32, four byte lanes

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- issue  input  1  instruction presented this cycle
- opcode  input  7  instruction opcode; acts only on 7'b0100011
- funct3  input  3  000 SB, 001 SH, 010 SW; others illegal
- imm  input  12  assembled S-type immediate {inst[31:25], inst[11:7]}
- in1  input  32  rs1 data (base address)
- in2  input  32  rs2 data (store data)
- busy  output  1  request outstanding; upstream must hold and not re-issue
- d_valid  output  1  write request valid
- d_ready  input  1  memory accepts request when d_valid && d_ready
- d_addr  output  ADDR_W  word-aligned address (low two bits zero)
- d_wdata  output  32  lane-steered store data
- d_be  output  4  byte enables, bit i = bits [8i+7:8i]
- st_done  output  1  one-cycle pulse after a completed write
- misalign  output  1  one-cycle pulse on rejected misaligned store (macro-gated)

## Operation
- States: IDLE, REQ.
- IDLE: accept when issue && opcode==7'b0100011 && funct3 legal. ea = in1 + {{20{imm[11]}}, imm}, modulo 2^32, truncated to ADDR_W.
- Lane steering by ea[1:0]: SB: d_wdata = {4{in2[7:0]}}, d_be = 4'b0001 << ea[1:0]. SH: d_wdata = {2{in2[15:0]}}, d_be = ea[1] ? 4'b1100 : 4'b0011. SW: d_wdata = in2, d_be = 4'b1111.
- On accept: register d_addr = {ea[ADDR_W-1:2], 2'b00}, d_wdata, d_be; go to REQ.
- REQ: d_valid=1, busy=1, outputs held stable until d_ready. On handshake: go IDLE, st_done pulses next cycle.
- Non-store opcode or illegal funct3 in IDLE: ignored, no state change, no pulse.
- issue while in REQ: ignored (upstream must respect busy).
- Misalignment: SH with ea[0]=1, SW with ea[1:0]!=0 (see Configuration).

## Timing
- Reset: state IDLE; busy, d_valid, st_done, misalign = 0; d_addr, d_wdata, d_be = 0.
- Accept in cycle N -> d_valid and busy high from N+1.
- d_ready high in N+1 -> handshake in N+1, busy/d_valid low in N+2, st_done high in N+2 only. Minimum issue-to-issue spacing 2 cycles.
- d_ready may be held low indefinitely; address/data/be must not change while d_valid high.
- d_ready with d_valid low: no effect.
- rst_n asserted mid-REQ: request dropped immediately (asynchronous); no st_done.
- busy is combinational from state (busy == d_valid).

## Configuration
- STORE_MISALIGN_CHECK_EN defined: misaligned SH/SW is not issued; misalign pulses one cycle in N+1; state stays IDLE; busy stays 0.
- Not defined: no check; SH uses ea[1] lane selection, SW forced to word address (ea[1:0] dropped); misalign tied 0.

## Structure
- Shared package (with load path): OPC_STORE=7'b0100011, OPC_LOAD, funct3 constants F3_SB/F3_SH/F3_SW, byte-enable type logic [3:0], state enum {IDLE, REQ}.
- Sub-module store_align: combinational (funct3, ea[1:0], in2) -> (d_wdata, d_be, misaligned); instantiated once; FSM and output registers in top.

## Test plan
- SW in1=0x1000, imm=0x004, in2=0xDEADBEEF, d_ready=1 at N+1 -> d_addr=0x1004, d_be=1111, d_wdata=0xDEADBEEF, st_done at N+2.
- SB in1=0x2003, imm=0xFFF (-1), in2=0x000000A5 -> ea=0x2002, d_addr=0x2000, d_be=0100, d_wdata=0xA5A5A5A5.
- SH ea=0x3002, in2=0x1234, d_ready low 5 cycles -> d_valid/busy held 5 cycles, outputs stable, one st_done after handshake.
- SW ea=0x4001: with macro -> misalign pulse, no d_valid; without -> d_addr=0x4000, d_be=1111.
- opcode=0000011 or funct3=011 with issue -> no d_valid, no pulses; rst_n low mid-REQ -> all outputs 0 immediately, no st_done.
